// File: rtl/mbist_march_pkg.sv
// mbist_march_pkg: FSM/op encodings and the March C- element table for mbist_march_ctrl
// Element table: E0 up{w0} E1 up{r0,w1} E2 up{r1,w0} E3 dn{r0,w1} E4 dn{r1,w0} E5 dn{r0}
package mbist_march_pkg;
  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_e;
  typedef enum logic [1:0] {W0, W1, R0, R1} op_e;
  localparam int MARCH_ELEM_LAST = 5;
  localparam logic [5:0] MARCH_UP = 6'b000111;
  localparam logic [5:0] MARCH_TWO_OPS = 6'b011110;
  localparam op_e MARCH_OP0 [6] = '{W0, R0, R1, R0, R1, R0};
  localparam op_e MARCH_OP1 [6] = '{W0, W1, W0, W1, W0, R0};
  function automatic op_e march_op(input logic [2:0] e, input logic o);
    return o ? MARCH_OP1[e] : MARCH_OP0[e];
  endfunction
endpackage

// File: rtl/mbist_march_cmp.sv
// mbist_march_cmp: one-cycle read-compare pipeline with first-fail capture
// Ports: clk, rst_n; clr (restart), rd/exp_data/addr/elem (read issue), rdata (memory data),
//        mismatch (compare this cycle), fail/fail_addr/fail_elem (sticky first-fail record)
module mbist_march_cmp #(
  parameter int ADDR_WD = 9,
  parameter int DATA_WD = 32,
  parameter int ELEM_WD = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               rd,
  input  logic [DATA_WD-1:0] exp_data,
  input  logic [ADDR_WD-1:0] addr,
  input  logic [ELEM_WD-1:0] elem,
  input  logic [DATA_WD-1:0] rdata,
  output logic               mismatch,
  output logic               fail,
  output logic [ADDR_WD-1:0] fail_addr,
  output logic [ELEM_WD-1:0] fail_elem
);
  logic               pend_q;
  logic [DATA_WD-1:0] exp_q;
  logic [ADDR_WD-1:0] addr_q;
  logic [ELEM_WD-1:0] elem_q;
  assign mismatch = pend_q && (rdata != exp_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      exp_q <= '0;
      addr_q <= '0;
      elem_q <= '0;
      fail <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      pend_q <= rd;
      if (rd) begin
        exp_q <= exp_data;
        addr_q <= addr;
        elem_q <= elem;
      end
      if (clr) begin
        fail <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
      end else if (mismatch && !fail) begin
        fail <= 1'b1;
        fail_addr <= addr_q;
        fail_elem <= elem_q;
      end
    end
  end
endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- sequencer driving address generator and memory, with pass/fail capture
// Ports: bist_en/bist_start (control), last_addr/bist_addr (address generator), mem_rdata (memory);
//        addr_run/addr_updown/addr_scan_load (address generator), mem_cs/mem_we/mem_wdata (memory),
//        bist_done/bist_fail/fail_addr/fail_elem (status)
// Macro MBIST_STOP_ON_FAIL_EN: stop the test at the first mismatch instead of completing all elements
module mbist_march_ctrl
  import mbist_march_pkg::*;
#(
  parameter int BIST_ADDR_WD = 9,
  parameter int BIST_DATA_WD = 32,
  parameter int BIST_ELEM_WD = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bist_en,
  input  logic                    bist_start,
  input  logic                    last_addr,
  input  logic [BIST_ADDR_WD-1:0] bist_addr,
  input  logic [BIST_DATA_WD-1:0] mem_rdata,
  output logic                    addr_run,
  output logic                    addr_updown,
  output logic                    addr_scan_load,
  output logic                    mem_cs,
  output logic                    mem_we,
  output logic [BIST_DATA_WD-1:0] mem_wdata,
  output logic                    bist_done,
  output logic                    bist_fail,
  output logic [BIST_ADDR_WD-1:0] fail_addr,
  output logic [BIST_ELEM_WD-1:0] fail_elem
);
`ifdef MBIST_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif
  state_e                  state_q, state_d;
  logic [BIST_ELEM_WD-1:0] elem_q, elem_d, elem_nx;
  logic                    op_q, op_d, done_q, rd, mismatch, stop, last_op;
  logic [2:0]              e, en;
  op_e                     cur;
  assign elem_nx = elem_q + 1'b1;
  assign e = 3'(elem_q);
  assign en = 3'(elem_nx);
  assign cur = march_op(e, op_q);
  assign last_op = op_q | ~MARCH_TWO_OPS[e];
  assign stop = STOP_EN & mismatch;
  assign bist_done = done_q;
  always_comb begin
    state_d = state_q;
    elem_d = elem_q;
    op_d = op_q;
    addr_run = 1'b0;
    addr_updown = 1'b1;
    addr_scan_load = 1'b0;
    mem_cs = 1'b0;
    mem_we = 1'b0;
    mem_wdata = '0;
    rd = 1'b0;
    case (state_q)
      IDLE: state_d = (bist_start && bist_en) ? INIT : IDLE;
      INIT: begin
        addr_scan_load = 1'b1;
        elem_d = '0;
        op_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        addr_updown = MARCH_UP[e];
        if (stop) state_d = DONE;
        else begin
          mem_cs = 1'b1;
          mem_we = (cur == W0) || (cur == W1);
          mem_wdata = {BIST_DATA_WD{cur == W1}};
          rd = !mem_we;
          op_d = !last_op;
          if (last_op && last_addr) begin
            if (elem_q == BIST_ELEM_WD'(MARCH_ELEM_LAST)) state_d = DRAIN;
            else begin
              elem_d = elem_nx;
              addr_run = MARCH_UP[e] == MARCH_UP[en];
            end
          end else addr_run = last_op;
        end
      end
      DRAIN: state_d = DONE;
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !bist_en) begin
      state_d = IDLE;
      addr_run = 1'b0;
      addr_scan_load = 1'b0;
      mem_cs = 1'b0;
      mem_we = 1'b0;
      mem_wdata = '0;
      rd = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      elem_q <= '0;
      op_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q <= elem_d;
      op_q <= op_d;
      done_q <= (state_q == INIT) ? 1'b0 : (done_q | (state_d == DONE));
    end
  end
  mbist_march_cmp #(
    .ADDR_WD(BIST_ADDR_WD),
    .DATA_WD(BIST_DATA_WD),
    .ELEM_WD(BIST_ELEM_WD)
  ) u_cmp (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state_q == INIT),
    .rd(rd),
    .exp_data({BIST_DATA_WD{cur == R1}}),
    .addr(bist_addr),
    .elem(elem_q),
    .rdata(mem_rdata),
    .mismatch(mismatch),
    .fail(bist_fail),
    .fail_addr(fail_addr),
    .fail_elem(fail_elem)
  );
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: directed self-checking bench with a 4-word memory and address generator model
module tb_mbist_march_ctrl;
  logic        clk, rst_n, bist_en, bist_start, last_addr;
  logic [8:0]  bist_addr;
  logic [31:0] mem_rdata, mem_wdata;
  logic        addr_run, addr_updown, addr_scan_load, mem_cs, mem_we, bist_done, bist_fail;
  logic [8:0]  fail_addr;
  logic [2:0]  fail_elem;
  logic        fault_en;
  logic [31:0] mem [4];
  logic [31:0] rd_val;
  int          n_chk, n_err;
  int          exp_addr [40];
  bit          exp_we [40], exp_val [40], exp_run [40], exp_up [40];
  logic [1:0]  tbl [6][2];
  int          d, n;
  mbist_march_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .bist_en(bist_en),
    .bist_start(bist_start),
    .last_addr(last_addr),
    .bist_addr(bist_addr),
    .mem_rdata(mem_rdata),
    .addr_run(addr_run),
    .addr_updown(addr_updown),
    .addr_scan_load(addr_scan_load),
    .mem_cs(mem_cs),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .bist_done(bist_done),
    .bist_fail(bist_fail),
    .fail_addr(fail_addr),
    .fail_elem(fail_elem)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign last_addr = addr_updown ? (bist_addr == 9'd3) : (bist_addr == 9'd0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bist_addr <= 9'd0;
    else if (addr_scan_load) bist_addr <= addr_updown ? 9'd0 : 9'd3;
    else if (addr_run) bist_addr <= addr_updown ? ((bist_addr == 9'd3) ? 9'd0 : bist_addr + 9'd1)
                                                : ((bist_addr == 9'd0) ? 9'd3 : bist_addr - 9'd1);
  end
  assign rd_val = mem[bist_addr[1:0]] & ~((fault_en && bist_addr == 9'd2) ? 32'd1 : 32'd0);
  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 32'd0;
    mem_rdata = 32'd0;
  end
  always @(posedge clk) begin
    if (mem_cs && mem_we) mem[bist_addr[1:0]] <= mem_wdata;
    if (mem_cs && !mem_we) mem_rdata <= rd_val;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_test(input int abort_at, output int done_cyc, output int n_cs);
    done_cyc = 0;
    n_cs = 0;
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    check("init_scan_load", 32'(addr_scan_load), 32'd1);
    check("init_updown", 32'(addr_updown), 32'd1);
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 1) check("fail_cleared", 32'(bist_fail), 32'd0);
      if (mem_cs) begin
        if (n_cs < 40) begin
          check("addr", 32'(bist_addr), 32'(exp_addr[n_cs]));
          check("we", 32'(mem_we), 32'(exp_we[n_cs]));
          if (exp_we[n_cs]) check("wdata", mem_wdata, {32{exp_val[n_cs]}});
          check("run", 32'(addr_run), 32'(exp_run[n_cs]));
          check("updown", 32'(addr_updown), 32'(exp_up[n_cs]));
        end
        n_cs++;
      end
      if (bist_done) begin
        done_cyc = c;
        break;
      end
      bist_start = (c == 5);
      if (c == abort_at) begin
        bist_start = 1'b0;
        bist_en = 1'b0;
        tick();
        break;
      end
    end
    bist_start = 1'b0;
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    tbl = '{'{2'b10, 2'b10}, '{2'b00, 2'b11}, '{2'b01, 2'b10},
            '{2'b00, 2'b11}, '{2'b01, 2'b10}, '{2'b00, 2'b00}};
    begin
      int i;
      i = 0;
      for (int e = 0; e < 6; e++) begin
        int nops;
        nops = (e == 0 || e == 5) ? 1 : 2;
        for (int k = 0; k < 4; k++) begin
          for (int o = 0; o < nops; o++) begin
            exp_addr[i] = (e < 3) ? k : 3 - k;
            exp_we[i] = tbl[e][o][1];
            exp_val[i] = tbl[e][o][0];
            exp_up[i] = (e < 3);
            exp_run[i] = (o == nops - 1) && !(k == 3 && (e == 2 || e == 5));
            i++;
          end
        end
      end
    end
    rst_n = 1'b0;
    bist_en = 1'b0;
    bist_start = 1'b0;
    fault_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_run", 32'(addr_run), 32'd0);
    check("rst_updown", 32'(addr_updown), 32'd1);
    check("rst_scan_load", 32'(addr_scan_load), 32'd0);
    check("rst_cs", 32'(mem_cs), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_done", 32'(bist_done), 32'd0);
    check("rst_fail", 32'(bist_fail), 32'd0);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    check("rst_fail_elem", 32'(fail_elem), 32'd0);
    rst_n = 1'b1;
    tick();
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    check("start_no_en_load", 32'(addr_scan_load), 32'd0);
    tick();
    check("start_no_en_cs", 32'(mem_cs), 32'd0);
    bist_en = 1'b1;
    tick();
    run_test(-1, d, n);
    check("clean_done_cycle", 32'(d), 32'd42);
    check("clean_cs_cycles", 32'(n), 32'd40);
    check("clean_fail", 32'(bist_fail), 32'd0);
    bist_en = 1'b0;
    tick();
    check("done_sticky", 32'(bist_done), 32'd1);
    check("idle_cs", 32'(mem_cs), 32'd0);
    bist_en = 1'b1;
    tick();
    fault_en = 1'b1;
    run_test(-1, d, n);
`ifdef MBIST_STOP_ON_FAIL_EN
    check("fault_done_cycle", 32'(d), 32'd19);
    check("fault_cs_cycles", 32'(n), 32'd17);
    tick();
    check("fault_stop_cs", 32'(mem_cs), 32'd0);
`else
    check("fault_done_cycle", 32'(d), 32'd42);
    check("fault_cs_cycles", 32'(n), 32'd40);
`endif
    check("fault_fail", 32'(bist_fail), 32'd1);
    check("fault_fail_addr", 32'(fail_addr), 32'd2);
    check("fault_fail_elem", 32'(fail_elem), 32'd2);
    bist_en = 1'b0;
    tick();
    bist_en = 1'b1;
    tick();
    run_test(18, d, n);
    check("abort18_cs", 32'(mem_cs), 32'd0);
    check("abort18_run", 32'(addr_run), 32'd0);
    check("abort18_done", 32'(bist_done), 32'd0);
    check("abort18_fail", 32'(bist_fail), 32'd1);
    check("abort18_fail_addr", 32'(fail_addr), 32'd2);
    check("abort18_fail_elem", 32'(fail_elem), 32'd2);
    repeat (3) tick();
    check("abort18_idle_cs", 32'(mem_cs), 32'd0);
    fault_en = 1'b0;
    bist_en = 1'b1;
    tick();
    run_test(10, d, n);
    check("abort10_cs", 32'(mem_cs), 32'd0);
    check("abort10_done", 32'(bist_done), 32'd0);
    check("abort10_fail", 32'(bist_fail), 32'd0);
    check("abort10_cs_cycles", 32'(n), 32'd10);
    bist_en = 1'b1;
    tick();
    run_test(-1, d, n);
    check("rerun_done_cycle", 32'(d), 32'd42);
    check("rerun_fail", 32'(bist_fail), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
